add_acc_unit: RTL and testbench
===============================

ADD_ACC_UNIT -- requirements
Module: add_acc_unit

Interface
REQ-001 Parameter WIDTH, default 8: operand, result and accumulator width; legal 4..32.
REQ-002 Parameter SIGNED, default 0: 0 = unsigned arithmetic, 1 = two's-complement.
REQ-003 Parameter SATURATE, default 0: 0 = wrap on overflow, 1 = clamp on overflow.
REQ-004 clk  input  1  sole clock; all state SHALL change on its rising edge only.
REQ-005 rst_n  input  1  reset, synchronous, active-low.
REQ-006 ena  input  1  global enable; low = full pipeline hold.
REQ-007 in_valid  input  1  operation presented.
REQ-008 in_ready  output  1  unit accepts operation this cycle.
REQ-009 mode  input  2  00 ADD, 01 SUB, 10 ACC, 11 LOAD.
REQ-010 op_a  input  WIDTH  first operand.
REQ-011 op_b  input  WIDTH  second operand / load value.
REQ-012 out_valid  output  1  result held on outputs.
REQ-013 out_ready  input  1  consumer takes result this cycle.
REQ-014 result  output  WIDTH  registered result.
REQ-015 carry  output  1  raw carry-out (ADD/ACC) or borrow (SUB); 0 for LOAD.
REQ-016 ovf  output  1  overflow for current SIGNED mode; with SATURATE=1, means clamp applied.
REQ-017 acc  output  WIDTH  current accumulator value.

Function
REQ-018 Two stages: S1 registers mode/op_a/op_b with s1_valid; S2 computes and registers result/flags/out_valid.
REQ-019 stall = (out_valid & ~out_ready) | ~ena; in_ready SHALL equal ~stall (combinational).
REQ-020 Transfer in = in_valid & in_ready; transfer out = out_valid & out_ready.
REQ-021 While stall=1, all S1, S2 and acc registers SHALL hold their values.
REQ-022 Latency: operation accepted in cycle N appears with out_valid=1 in cycle N+2 when not stalled; throughput one op/cycle.
REQ-023 When not stalled, S2 SHALL load from S1; if s1_valid=0, out_valid SHALL go 0 next cycle.
REQ-024 ADD: result = op_a+op_b; SUB: result = op_a-op_b; ACC: result = acc+op_a, op_b ignored; LOAD: result = op_b.
REQ-025 acc SHALL update to result only when an ACC or LOAD op is captured into S2; ADD/SUB leave acc unchanged.
REQ-026 Back-to-back ACC ops SHALL chain: each uses the acc written by the previous one; no bubble required.
REQ-027 Unsigned ovf = carry (ADD/ACC) or borrow (SUB); signed ovf = operand signs equal (for SUB: differ) and result sign differs.
REQ-028 SATURATE=1: unsigned overflow clamps to all-ones (ADD/ACC) or zero (SUB); signed clamps to max positive or min negative by direction of overflow.
REQ-029 Saturated value SHALL also be what ACC writes to acc.
REQ-030 Sums wrap modulo 2^WIDTH when SATURATE=0; carry/ovf still reported.
REQ-031 Output data SHALL stay stable while out_valid=1 and out_ready=0.
REQ-032 in_valid while in_ready=0 SHALL be ignored; no op is lost or duplicated.

Reset
REQ-033 rst_n low at a clock edge SHALL clear s1_valid, out_valid, result, carry, ovf, acc to 0, overriding ena and stall.
REQ-034 Operations in flight at reset SHALL be discarded; in_ready SHALL be 1 in the first cycle after release if ena=1.

Structure
REQ-035 Package add_acc_pkg SHALL hold the mode encodings (MODE_ADD/SUB/ACC/LOAD) and default WIDTH.
REQ-036 Sub-module add_acc_core (combinational: operands, mode, SIGNED, SATURATE -> result, carry, ovf) SHALL hold all arithmetic; add_acc_unit holds pipeline and handshake.

Verification
REQ-037 WIDTH=8, unsigned, wrap: ADD 200+100 -> result 44, carry 1, ovf 1, two cycles after accept.
REQ-038 Unsigned, SATURATE=1: SUB 5-9 -> result 0, carry 1, ovf 1; ADD 250+10 -> 255, ovf 1.
REQ-039 SIGNED=1, SATURATE=1: ADD 100+100 -> 127, ovf 1; SUB -100-100 -> -128, ovf 1.
REQ-040 LOAD 10 then ACC 5, ACC 7, ACC 3 back-to-back -> results 10,15,22,25; acc ends 25.
REQ-041 out_ready low 3 cycles with 4 ops streamed -> in_ready low while stalled, results unchanged, all 4 delivered in order, none dropped.
REQ-042 rst_n low for one cycle with 2 ops in flight -> out_valid 0, acc 0, no stale result after release.

Source files
------------

// File: rtl/add_acc_pkg.sv
// Shared definitions for the add/accumulate unit: operation encodings and default width.
package add_acc_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    MODE_ADD  = 2'b00,
    MODE_SUB  = 2'b01,
    MODE_ACC  = 2'b10,
    MODE_LOAD = 2'b11
  } mode_e;

endpackage

// File: rtl/add_acc_core.sv
// Combinational arithmetic for the add/accumulate unit.
// Computes the result, the raw carry/borrow and the overflow flag, with optional clamping.
module add_acc_core
  import add_acc_pkg::*;
#(
  parameter int WIDTH    = DEFAULT_WIDTH,
  parameter int SIGNED   = 0,
  parameter int SATURATE = 0
) (
  input  logic [1:0]       mode_i,
  input  logic [WIDTH-1:0] op_a_i,
  input  logic [WIDTH-1:0] op_b_i,
  input  logic [WIDTH-1:0] acc_i,
  output logic [WIDTH-1:0] result_o,
  output logic             carry_o,
  output logic             ovf_o
);

  logic [WIDTH-1:0] x, y, raw, sat_val;
  logic [WIDTH:0]   full;
  logic             is_sub, ovf;

  always_comb begin
    x       = (mode_i == MODE_ACC) ? acc_i : op_a_i;
    y       = (mode_i == MODE_ACC) ? op_a_i : op_b_i;
    is_sub  = (mode_i == MODE_SUB);
    full    = is_sub ? ({1'b0, x} - {1'b0, y}) : ({1'b0, x} + {1'b0, y});
    raw     = full[WIDTH-1:0];
    ovf     = 1'b0;
    sat_val = '0;

    // Signed overflow always pushes away from the sign of the first operand.
    if (SIGNED != 0) begin
      if (is_sub) ovf = (x[WIDTH-1] != y[WIDTH-1]) && (raw[WIDTH-1] != x[WIDTH-1]);
      else        ovf = (x[WIDTH-1] == y[WIDTH-1]) && (raw[WIDTH-1] != x[WIDTH-1]);
      sat_val = x[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
    end else begin
      ovf     = full[WIDTH];
      sat_val = is_sub ? '0 : '1;
    end

    result_o = ((SATURATE != 0) && ovf) ? sat_val : raw;
    carry_o  = full[WIDTH];
    ovf_o    = ovf;

    if (mode_i == MODE_LOAD) begin
      result_o = op_b_i;
      carry_o  = 1'b0;
      ovf_o    = 1'b0;
    end
  end

endmodule

// File: rtl/add_acc_unit.sv
// Two-stage add/sub/accumulate pipeline with valid/ready handshake and a global enable.
// S1 captures the operation, S2 registers the arithmetic result, flags and the accumulator.
module add_acc_unit
  import add_acc_pkg::*;
#(
  parameter int WIDTH    = DEFAULT_WIDTH,
  parameter int SIGNED   = 0,
  parameter int SATURATE = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ena,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             carry,
  output logic             ovf,
  output logic [WIDTH-1:0] acc
);

  logic             s1_valid_q, s1_valid_d;
  logic [1:0]       s1_mode_q, s1_mode_d;
  logic [WIDTH-1:0] s1_a_q, s1_a_d, s1_b_q, s1_b_d;
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] result_q, result_d, acc_q, acc_d;
  logic             carry_q, carry_d, ovf_q, ovf_d;
  logic [WIDTH-1:0] core_result;
  logic             core_carry, core_ovf;
  logic             stall;

  add_acc_core #(
    .WIDTH    (WIDTH),
    .SIGNED   (SIGNED),
    .SATURATE (SATURATE)
  ) u_core (
    .mode_i   (s1_mode_q),
    .op_a_i   (s1_a_q),
    .op_b_i   (s1_b_q),
    .acc_i    (acc_q),
    .result_o (core_result),
    .carry_o  (core_carry),
    .ovf_o    (core_ovf)
  );

  assign stall    = (out_valid_q & ~out_ready) | ~ena;
  assign in_ready = ~stall;

  // ACC chaining needs no bypass: the accumulator is written on the same edge the op leaves S1.
  always_comb begin
    s1_valid_d  = s1_valid_q;
    s1_mode_d   = s1_mode_q;
    s1_a_d      = s1_a_q;
    s1_b_d      = s1_b_q;
    out_valid_d = out_valid_q;
    result_d    = result_q;
    carry_d     = carry_q;
    ovf_d       = ovf_q;
    acc_d       = acc_q;
    if (!stall) begin
      s1_valid_d = in_valid;
      if (in_valid) begin
        s1_mode_d = mode;
        s1_a_d    = op_a;
        s1_b_d    = op_b;
      end
      out_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        result_d = core_result;
        carry_d  = core_carry;
        ovf_d    = core_ovf;
        if ((s1_mode_q == MODE_ACC) || (s1_mode_q == MODE_LOAD)) acc_d = core_result;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_valid_q  <= 1'b0;
      s1_mode_q   <= '0;
      s1_a_q      <= '0;
      s1_b_q      <= '0;
      out_valid_q <= 1'b0;
      result_q    <= '0;
      carry_q     <= 1'b0;
      ovf_q       <= 1'b0;
      acc_q       <= '0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_mode_q   <= s1_mode_d;
      s1_a_q      <= s1_a_d;
      s1_b_q      <= s1_b_d;
      out_valid_q <= out_valid_d;
      result_q    <= result_d;
      carry_q     <= carry_d;
      ovf_q       <= ovf_d;
      acc_q       <= acc_d;
    end
  end

  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign carry     = carry_q;
  assign ovf       = ovf_q;
  assign acc       = acc_q;

endmodule

// File: tb/tb_add_acc_unit.sv
// Bench for add_acc_unit: three configurations (wrap, unsigned clamp, signed clamp) share stimulus
// and are checked against a value-level model through an in-order scoreboard.
module tb_add_acc_unit;
  import add_acc_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0, ena = 1'b1, in_valid = 1'b0, out_ready = 1'b1;
  logic [1:0] mode = 2'b00;
  logic [7:0] op_a = 8'd0, op_b = 8'd0;

  logic       in_ready, in_ready_u, in_ready_s;
  logic       ov_w, ov_u, ov_s, cy_w, cy_u, cy_s, of_w, of_u, of_s;
  logic [7:0] res_w, res_u, res_s, acc_w, acc_u, acc_s;

  add_acc_unit #(.WIDTH(8), .SIGNED(0), .SATURATE(0)) u_wrap (
    .clk(clk), .rst_n(rst_n), .ena(ena), .in_valid(in_valid), .in_ready(in_ready),
    .mode(mode), .op_a(op_a), .op_b(op_b), .out_valid(ov_w), .out_ready(out_ready),
    .result(res_w), .carry(cy_w), .ovf(of_w), .acc(acc_w));
  add_acc_unit #(.WIDTH(8), .SIGNED(0), .SATURATE(1)) u_usat (
    .clk(clk), .rst_n(rst_n), .ena(ena), .in_valid(in_valid), .in_ready(in_ready_u),
    .mode(mode), .op_a(op_a), .op_b(op_b), .out_valid(ov_u), .out_ready(out_ready),
    .result(res_u), .carry(cy_u), .ovf(of_u), .acc(acc_u));
  add_acc_unit #(.WIDTH(8), .SIGNED(1), .SATURATE(1)) u_ssat (
    .clk(clk), .rst_n(rst_n), .ena(ena), .in_valid(in_valid), .in_ready(in_ready_s),
    .mode(mode), .op_a(op_a), .op_b(op_b), .out_valid(ov_s), .out_ready(out_ready),
    .result(res_s), .carry(cy_s), .ovf(of_s), .acc(acc_s));

  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0]       vld;
    logic [2:0][7:0]  res;
    logic [2:0]       cy;
    logic [2:0]       ov;
    logic [2:0][7:0]  ac;
  } exp_t;

  exp_t            sbq[$];
  logic [2:0][7:0] macc = '0;
  int              checks = 0, errors = 0, delivered = 0;

  logic [1:0] st_mode [4] = '{MODE_ADD, MODE_SUB, MODE_LOAD, MODE_ACC};
  logic [7:0] st_a    [4] = '{8'd1, 8'd9, 8'd0, 8'd2};
  logic [7:0] st_b    [4] = '{8'd2, 8'd4, 8'd40, 8'd0};

  // Value-level reference: returns {ovf, carry, result}.
  function automatic logic [9:0] model(input logic [1:0] md, input logic [7:0] a, input logic [7:0] b,
                                       input logic [7:0] ac, input bit sgn, input bit sat);
    logic [7:0]  xv, yv, r;
    logic [31:0] tv;
    int          t, ts;
    logic        c, o;
    if (md == MODE_LOAD) return {2'b00, b};
    xv = (md == MODE_ACC) ? ac : a;
    yv = (md == MODE_ACC) ? a : b;
    if (md == MODE_SUB) begin
      t  = int'(xv) - int'(yv);
      ts = int'($signed(xv)) - int'($signed(yv));
      c  = (t < 0);
    end else begin
      t  = int'(xv) + int'(yv);
      ts = int'($signed(xv)) + int'($signed(yv));
      c  = (t > 255);
    end
    tv = t;
    r  = tv[7:0];
    o  = sgn ? ((ts > 127) || (ts < -128)) : c;
    if (sat && o) r = sgn ? ((ts > 127) ? 8'h7f : 8'h80) : ((md == MODE_SUB) ? 8'h00 : 8'hff);
    return {o, c, r};
  endfunction

  always @(negedge clk) begin
    exp_t       e, got;
    logic [9:0] m;
    if (!rst_n) begin
      sbq.delete();
      macc = '0;
    end else begin
      if (ov_w && out_ready && ena) begin
        checks++;
        if (sbq.size() == 0) begin
          errors++;
          $display("FAIL unexpected_output result=%0d required no output", res_w);
        end else begin
          e = sbq.pop_front();
          got.vld = {ov_s, ov_u, ov_w};
          got.res = {res_s, res_u, res_w};
          got.cy  = {cy_s, cy_u, cy_w};
          got.ov  = {of_s, of_u, of_w};
          got.ac  = {acc_s, acc_u, acc_w};
          if (got !== e) begin
            errors++;
            $display("FAIL scoreboard got=%h required=%h", got, e);
          end
          delivered++;
        end
      end
      if (in_valid && in_ready) begin
        e.vld = 3'b111;
        for (int k = 0; k < 3; k++) begin
          m = model(mode, op_a, op_b, macc[k], (k == 2), (k != 0));
          e.res[k] = m[7:0];
          e.cy[k]  = m[8];
          e.ov[k]  = m[9];
          if ((mode == MODE_ACC) || (mode == MODE_LOAD)) macc[k] = m[7:0];
          e.ac[k] = macc[k];
        end
        sbq.push_back(e);
      end
    end
  end

  task automatic test_reset;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; ena = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    checks++; if (ov_w !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%b required=0", ov_w); end
    checks++; if (res_w !== 8'd0) begin errors++; $display("FAIL reset_result got=%0d required=0", res_w); end
    checks++; if (cy_w !== 1'b0) begin errors++; $display("FAIL reset_carry got=%b required=0", cy_w); end
    checks++; if (of_w !== 1'b0) begin errors++; $display("FAIL reset_ovf got=%b required=0", of_w); end
    checks++; if (acc_w !== 8'd0) begin errors++; $display("FAIL reset_acc got=%0d required=0", acc_w); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got=%b required=1", in_ready); end
  endtask

  task automatic test_latency;
    @(posedge clk); #1;
    in_valid = 1'b1; mode = MODE_ADD; op_a = 8'd200; op_b = 8'd100; out_ready = 1'b1;
    @(negedge clk);
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL lat_accept in_ready=%b required=1", in_ready); end
    @(posedge clk); #1 in_valid = 1'b0;
    @(negedge clk);
    checks++; if (ov_w !== 1'b0) begin errors++; $display("FAIL lat_n1 out_valid=%b required=0", ov_w); end
    @(negedge clk);
    checks++;
    if ({ov_w, res_w, cy_w, of_w} !== {1'b1, 8'd44, 1'b1, 1'b1}) begin
      errors++;
      $display("FAIL lat_n2 valid=%b result=%0d carry=%b ovf=%b required 1/44/1/1", ov_w, res_w, cy_w, of_w);
    end
  endtask

  task automatic test_saturate;
    logic [1:0] md [4] = '{MODE_SUB, MODE_ADD, MODE_ADD, MODE_SUB};
    logic [7:0] a  [4] = '{8'd5, 8'd250, 8'd100, 8'h9c};
    logic [7:0] b  [4] = '{8'd9, 8'd10, 8'd100, 8'd100};
    logic [7:0] er [4] = '{8'd0, 8'd255, 8'h7f, 8'h80};
    logic [7:0] gr;
    logic       go, gc;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      in_valid = 1'b1; mode = md[i]; op_a = a[i]; op_b = b[i];
      @(posedge clk); #1 in_valid = 1'b0;
      @(posedge clk);
      @(negedge clk);
      gr = (i < 2) ? res_u : res_s;
      go = (i < 2) ? of_u : of_s;
      gc = cy_u;
      checks++;
      if ((gr !== er[i]) || (go !== 1'b1) || ((i == 0) && (gc !== 1'b1))) begin
        errors++;
        $display("FAIL sat_%0d result=%0d ovf=%b carry=%b required result=%0d ovf=1", i, gr, go, gc, er[i]);
      end
    end
  endtask

  task automatic test_acc_chain;
    logic [1:0] md [4] = '{MODE_LOAD, MODE_ACC, MODE_ACC, MODE_ACC};
    logic [7:0] a  [4] = '{8'd0, 8'd5, 8'd7, 8'd3};
    logic [7:0] b  [4] = '{8'd10, 8'd0, 8'd0, 8'd0};
    logic [7:0] er [4] = '{8'd10, 8'd15, 8'd22, 8'd25};
    out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      if (i < 4) begin in_valid = 1'b1; mode = md[i]; op_a = a[i]; op_b = b[i]; end
      else in_valid = 1'b0;
      @(negedge clk);
      if (i < 4) begin
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL chain_ready_%0d got=%b required=1", i, in_ready); end
      end
      if (i >= 2) begin
        checks++;
        if ((ov_w !== 1'b1) || (res_w !== er[i-2])) begin
          errors++; $display("FAIL chain_%0d valid=%b result=%0d required=%0d", i - 2, ov_w, res_w, er[i-2]);
        end
      end
    end
    checks++; if (acc_w !== 8'd25) begin errors++; $display("FAIL chain_acc got=%0d required=25", acc_w); end
  endtask

  task automatic test_stall;
    int         sent = 0, cyc = 0, held_cnt = 0, d0;
    logic [7:0] held = 8'd0;
    d0 = delivered;
    while (((sent < 4) || (delivered - d0 < 4)) && (cyc < 60)) begin
      @(posedge clk); #1;
      cyc++;
      if (sent < 4) begin in_valid = 1'b1; mode = st_mode[sent]; op_a = st_a[sent]; op_b = st_b[sent]; end
      else in_valid = 1'b0;
      if (ov_w && (held_cnt < 3)) begin out_ready = 1'b0; held_cnt++; end
      else out_ready = 1'b1;
      @(negedge clk);
      if (!out_ready) begin
        checks++;
        if ({in_ready, in_ready_u, in_ready_s} !== 3'b000) begin
          errors++; $display("FAIL stall_in_ready got=%b%b%b required=000", in_ready, in_ready_u, in_ready_s);
        end
        if (held_cnt > 1) begin
          checks++; if (res_w !== held) begin errors++; $display("FAIL stall_hold result=%0d required=%0d", res_w, held); end
        end
        held = res_w;
      end
      if (in_valid && in_ready) sent++;
    end
    in_valid = 1'b0; out_ready = 1'b1;
    checks++;
    if ((delivered - d0 != 4) || (held_cnt != 3)) begin
      errors++; $display("FAIL stall_delivered got=%0d required=4 (stalls=%0d)", delivered - d0, held_cnt);
    end
  endtask

  task automatic test_enable;
    @(posedge clk); #1;
    in_valid = 1'b1; mode = MODE_ADD; op_a = 8'd3; op_b = 8'd4; out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; ena = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      checks++;
      if ((in_ready !== 1'b0) || (ov_w !== 1'b0)) begin
        errors++; $display("FAIL ena_hold_%0d in_ready=%b out_valid=%b required 0/0", i, in_ready, ov_w);
      end
      @(posedge clk);
    end
    #1 ena = 1'b1;
    @(negedge clk);
    checks++; if ((ov_w !== 1'b0) || (in_ready !== 1'b1)) begin
      errors++; $display("FAIL ena_resume out_valid=%b in_ready=%b required 0/1", ov_w, in_ready);
    end
    @(negedge clk);
    checks++; if ((ov_w !== 1'b1) || (res_w !== 8'd7)) begin
      errors++; $display("FAIL ena_result valid=%b result=%0d required 1/7", ov_w, res_w);
    end
  endtask

  task automatic test_reset_in_flight;
    out_ready = 1'b0;
    @(posedge clk); #1 in_valid = 1'b1; mode = MODE_LOAD; op_a = 8'd0; op_b = 8'd77;
    @(posedge clk); #1 in_valid = 1'b1; mode = MODE_ACC; op_a = 8'd1;
    @(posedge clk); #1 in_valid = 1'b0; rst_n = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    checks++;
    if ((ov_w !== 1'b0) || (acc_w !== 8'd0) || (in_ready !== 1'b1)) begin
      errors++; $display("FAIL rst_flight out_valid=%b acc=%0d in_ready=%b required 0/0/1", ov_w, acc_w, in_ready);
    end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++; if (ov_w !== 1'b0) begin errors++; $display("FAIL rst_stale_%0d out_valid=%b required=0", i, ov_w); end
    end
  endtask

  task automatic test_random;
    int sent = 0, cyc = 0;
    bit took = 1'b1;
    while ((sent < 40) && (cyc < 400)) begin
      @(posedge clk); #1;
      cyc++;
      if (took || !in_valid) begin
        in_valid = ($urandom_range(0, 4) != 0);
        mode = 2'($urandom_range(0, 3));
        op_a = 8'($urandom);
        op_b = 8'($urandom);
      end
      out_ready = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      took = in_valid && in_ready;
      if (took) sent++;
    end
    in_valid = 1'b0; out_ready = 1'b1;
    checks++; if (sent != 40) begin errors++; $display("FAIL random_budget sent=%0d required=40", sent); end
  endtask

  initial begin
    test_reset();
    test_latency();
    test_saturate();
    test_acc_chain();
    test_stall();
    test_enable();
    test_reset_in_flight();
    test_random();
    repeat (6) @(posedge clk);
    @(negedge clk);
    checks++; if (sbq.size() != 0) begin errors++; $display("FAIL drain pending=%0d required=0", sbq.size()); end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
